wb_encoder_poller: RTL and testbench
====================================

WB_ENCODER_POLLER -- requirements
Module: wb_encoder_poller

Purpose: Wishbone master that periodically sweeps NCH quadrature-encoder peripherals, snapshots counts, computes per-period deltas, and exposes results on a Wishbone slave port.

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of encoder channels (1..8).
REQ-002 SHALL have parameter PERIOD, default 100000, meaning clocks between sweep starts (>= 16).
REQ-003 SHALL have parameter BASE_ADDR, default 30'h100, meaning word address of channel 0.
REQ-004 SHALL have parameter STRIDE, default 1, meaning word-address step between channels.
REQ-005 SHALL have parameter TIMEOUT, default 64, meaning clocks to wait for a master ack.
REQ-006 SHALL have ports: i_clk input 1, clock; i_reset input 1, reset (synchronous, active-high).
REQ-007 SHALL have slave ports: i_s_cyc, i_s_stb, i_s_we input 1; i_s_addr input 30; i_s_data input 32; i_s_sel input 4; o_s_ack output 1; o_s_stall output 1; o_s_data output 32.
REQ-008 SHALL have master ports: o_m_cyc, o_m_stb, o_m_we output 1; o_m_addr output 30; o_m_data output 32; o_m_sel output 4; i_m_ack, i_m_stall input 1; i_m_data input 32.
REQ-009 SHALL have o_sweep_done output 1, one-cycle pulse when a sweep completes.

Function
REQ-010 SHALL hold o_m_we=0, o_m_data=0, o_m_sel=4'hF at all times (read-only master).
REQ-011 SHALL run a period counter 0..PERIOD-1 only while CTRL.enable=1; at PERIOD-1 it wraps to 0 and raises a tick; counter holds 0 while disabled.
REQ-012 SHALL use states IDLE, REQ, WAIT, STORE; IDLE->REQ on tick with ch=0.
REQ-013 In REQ: o_m_cyc=1, o_m_stb=1, o_m_addr=BASE_ADDR+ch*STRIDE; move to WAIT on first cycle with i_m_stall=0.
REQ-014 In WAIT: o_m_cyc=1, o_m_stb=0; on i_m_ack latch i_m_data and go STORE; ack in the same cycle stb is accepted also valid (REQ->STORE directly).
REQ-015 Timeout counter SHALL start at REQ entry; if TIMEOUT clocks elapse without ack, drop cyc, set ERR bit ch, leave count/delta for ch unchanged, go STORE-skip to next channel.
REQ-016 In STORE: delta[ch] <= data - count[ch] (32-bit modulo, wraps naturally), count[ch] <= data; then ch+1 -> REQ, or after ch=NCH-1 -> IDLE, SEQ <= SEQ+1, o_sweep_done=1 for one cycle.
REQ-017 o_m_cyc SHALL deassert for at least one cycle between channel transactions.
REQ-018 A tick arriving while not IDLE SHALL be dropped and set STATUS.overrun.
REQ-019 Clearing CTRL.enable mid-sweep SHALL let the current sweep finish; no further ticks.
REQ-020 First sweep after reset SHALL report delta = count - 0.
REQ-021 Slave SHALL ack every cyc&stb exactly one cycle later, o_s_stall=0 always, o_s_data=0 when not acking.
REQ-022 Slave map (word offset i_s_addr[4:0]): 0 CTRL {enable[0]} RW; 1 STATUS {busy[31], overrun[16], err[NCH-1:0]} R; 2 SEQ R; 3 reserved reads 0; 4+2k count[k]; 5+2k delta[k]; beyond map reads 0.
REQ-023 Write to CTRL SHALL set enable from i_s_data[0] if i_s_sel[0]; write to STATUS with data bit 0 = 1 SHALL clear err and overrun; other writes acked and ignored.
REQ-024 Error/overrun set and software clear in the same cycle: set SHALL win.

Reset
REQ-025 On i_reset: state IDLE, ch=0, enable=0, period counter 0, count/delta/SEQ/err/overrun 0, o_m_cyc=o_m_stb=0, o_s_ack=0, o_s_data=0, o_sweep_done=0.
REQ-026 Reset mid-transaction SHALL drop o_m_cyc the next cycle; a late i_m_ack after reset SHALL be ignored.

Verification (NCH=2, PERIOD=100, BASE=0x100, STRIDE=1, TIMEOUT=8)
REQ-027 Write CTRL=1; slaves return 5 and 7 -> reads at 0x100 then 0x101, count={5,7}, delta={5,7}, SEQ=1, o_sweep_done pulse.
REQ-028 Second sweep returns 3 and 0xFFFFFFFF -> delta[0]=0xFFFFFFFE, delta[1]=0xFFFFFFF8, SEQ=2.
REQ-029 Channel 1 never acks -> cyc dropped after 8 clocks, STATUS.err=2'b10, count[1] unchanged, SEQ increments; write STATUS=1 clears err.
REQ-030 Slave holds i_m_stall=1 for 150 clocks -> next tick dropped, STATUS.overrun=1.
REQ-031 Assert i_reset during WAIT -> o_m_cyc=0 next cycle, all registers read 0, no sweep until enable rewritten.

Source files
------------

// File: rtl/wb_encoder_poller.sv
// Wishbone encoder poller.
// A read-only Wishbone master sweeps NCH encoder count registers once per
// PERIOD clocks, keeps the latest count and the per-period delta for each
// channel, and publishes them through a small Wishbone slave register map.
module wb_encoder_poller #(
    parameter int          NCH       = 2,
    parameter int          PERIOD    = 100000,
    parameter logic [29:0] BASE_ADDR = 30'h100,
    parameter int          STRIDE    = 1,
    parameter int          TIMEOUT   = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // Wishbone slave (register map)
    input  logic        i_s_cyc,
    input  logic        i_s_stb,
    input  logic        i_s_we,
    input  logic [29:0] i_s_addr,
    input  logic [31:0] i_s_data,
    input  logic [3:0]  i_s_sel,
    output logic        o_s_ack,
    output logic        o_s_stall,
    output logic [31:0] o_s_data,
    // Wishbone master (encoder sweep)
    output logic        o_m_cyc,
    output logic        o_m_stb,
    output logic        o_m_we,
    output logic [29:0] o_m_addr,
    output logic [31:0] o_m_data,
    output logic [3:0]  o_m_sel,
    input  logic        i_m_ack,
    input  logic        i_m_stall,
    input  logic [31:0] i_m_data,
    // Sweep completion strobe
    output logic        o_sweep_done
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PER_W = $clog2(PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STORE
    } state_t;

    state_t             state, next_state;
    logic [CH_W-1:0]    ch;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [PER_W-1:0]   per_cnt;
    logic               enable;
    logic [NCH-1:0]     err;
    logic               overrun;
    logic [31:0]        seq;
    logic [31:0]        rd_data;
    logic               skip;
    logic [31:0]        count [NCH];
    logic [31:0]        delta [NCH];

    logic               tick;
    logic               last_ch;
    logic               tmo_hit;
    logic               take_ack;
    logic               tmo_fire;
    logic [NCH-1:0]     err_set;

    logic               s_req;
    logic [4:0]         s_off;
    logic               ctrl_wr;
    logic               status_clr;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    // The master never writes, so data/we are tied off and all byte lanes are read.
    assign o_m_we   = 1'b0;
    assign o_m_data = 32'h0;
    assign o_m_sel  = 4'hF;
    assign o_m_addr = BASE_ADDR + (30'(ch) * 30'(STRIDE));

    assign o_s_stall   = 1'b0;
    assign unused_bits = ^{i_s_addr[29:5], i_s_sel[3:1], i_s_data[31:1]};

    assign tick    = enable && (per_cnt == PER_W'(PERIOD - 1));
    assign last_ch = (ch == CH_W'(NCH - 1));
    assign tmo_hit = (tmo_cnt >= TMO_W'(TIMEOUT - 1));

    // Period counter: free-runs only while enabled, parked at zero otherwise.
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of block evaluation order.
        if (i_reset || !enable) begin
            per_cnt <= '0;
        end else if (per_cnt == PER_W'(PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end

    // Sweep FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sweep FSM next-state and bus outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first; any path that
        // left one unassigned would infer a latch.
        next_state = state;
        o_m_cyc    = 1'b0;
        o_m_stb    = 1'b0;
        take_ack   = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                o_m_cyc = 1'b1;
                o_m_stb = 1'b1;
                if (!i_m_stall) begin
                    // An ack in the accept cycle completes the transfer at once.
                    take_ack   = i_m_ack;
                    next_state = i_m_ack ? S_STORE : S_WAIT;
                end
            end
            S_WAIT: begin
                o_m_cyc = 1'b1;
                if (i_m_ack) begin
                    take_ack   = 1'b1;
                    next_state = S_STORE;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    next_state = S_STORE;
                end
            end
            S_STORE: begin
                // cyc is low here, giving the required gap between channels.
                next_state = last_ch ? S_IDLE : S_REQ;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Per-channel error strobe for a timed-out transfer.
    always_comb begin
        err_set = '0;
        for (int k = 0; k < NCH; k++) begin
            err_set[k] = tmo_fire && (ch == CH_W'(k));
        end
    end

    // Sweep datapath: channel index, ack timeout, captured data, results.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ch           <= '0;
            tmo_cnt      <= '0;
            rd_data      <= '0;
            skip         <= 1'b0;
            seq          <= '0;
            o_sweep_done <= 1'b0;
            // NOTE: count/delta are a handful of flops, not a RAM, and the first
            // sweep's delta must be measured from zero, so they are reset.
            for (int k = 0; k < NCH; k++) begin
                count[k] <= '0;
                delta[k] <= '0;
            end
        end else begin
            o_sweep_done <= (state == S_STORE) && last_ch;

            // The timeout only advances once the slave has taken the strobe, so
            // a slave that stalls is waited on rather than abandoned.
            if (state == S_IDLE || state == S_STORE) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT || !i_m_stall) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (take_ack) begin
                rd_data <= i_m_data;
                skip    <= 1'b0;
            end else if (tmo_fire) begin
                skip    <= 1'b1;
            end

            if (state == S_IDLE) begin
                ch <= '0;
            end else if (state == S_STORE) begin
                if (!skip) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (ch == CH_W'(k)) begin
                            delta[k] <= rd_data - count[k];
                            count[k] <= rd_data;
                        end
                    end
                end
                if (last_ch) begin
                    seq <= seq + 32'd1;
                end else begin
                    ch <= ch + CH_W'(1);
                end
            end
        end
    end

    // Control/status: enable bit, sticky error and overrun flags (set beats clear).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            enable  <= 1'b0;
            err     <= '0;
            overrun <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= i_s_data[0];
            end
            err     <= (status_clr ? '0 : err) | err_set;
            overrun <= (status_clr ? 1'b0 : overrun) | (tick && (state != S_IDLE));
        end
    end

    // Slave decode and read mux.
    always_comb begin
        s_req      = i_s_cyc && i_s_stb;
        s_off      = i_s_addr[4:0];
        ctrl_wr    = s_req && i_s_we && (s_off == 5'd0) && i_s_sel[0];
        status_clr = s_req && i_s_we && (s_off == 5'd1) && i_s_data[0];
        rd_mux     = '0;
        if (s_off == 5'd0) begin
            rd_mux[0] = enable;
        end else if (s_off == 5'd1) begin
            rd_mux[31]      = (state != S_IDLE);
            rd_mux[16]      = overrun;
            rd_mux[NCH-1:0] = err;
        end else if (s_off == 5'd2) begin
            rd_mux = seq;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (s_off == 5'(4 + 2 * k)) begin
                    rd_mux = count[k];
                end else if (s_off == 5'(5 + 2 * k)) begin
                    rd_mux = delta[k];
                end
            end
        end
    end

    // Slave response: ack one cycle after each request, data only while acking.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_s_ack  <= 1'b0;
            o_s_data <= '0;
        end else begin
            o_s_ack  <= s_req;
            o_s_data <= (s_req && !i_s_we) ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_encoder_poller.sv
// Directed bench for wb_encoder_poller: an encoder-slave model answers the
// master port, register reads are scored against expected values queued at issue.
module tb_wb_encoder_poller;

    localparam int          NCH     = 2;
    localparam int          PERIOD  = 100;
    localparam int          TIMEOUT = 8;
    localparam logic [29:0] BASE    = 30'h100;

    logic        i_clk;
    logic        i_reset;
    logic        i_s_cyc, i_s_stb, i_s_we;
    logic [29:0] i_s_addr;
    logic [31:0] i_s_data;
    logic [3:0]  i_s_sel;
    logic        o_s_ack, o_s_stall;
    logic [31:0] o_s_data;
    logic        o_m_cyc, o_m_stb, o_m_we;
    logic [29:0] o_m_addr;
    logic [31:0] o_m_data;
    logic [3:0]  o_m_sel;
    logic        i_m_ack, i_m_stall;
    logic [31:0] i_m_data;
    logic        o_sweep_done;

    wb_encoder_poller #(
        .NCH(NCH), .PERIOD(PERIOD), .BASE_ADDR(BASE), .STRIDE(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_s_cyc(i_s_cyc), .i_s_stb(i_s_stb), .i_s_we(i_s_we),
        .i_s_addr(i_s_addr), .i_s_data(i_s_data), .i_s_sel(i_s_sel),
        .o_s_ack(o_s_ack), .o_s_stall(o_s_stall), .o_s_data(o_s_data),
        .o_m_cyc(o_m_cyc), .o_m_stb(o_m_stb), .o_m_we(o_m_we),
        .o_m_addr(o_m_addr), .o_m_data(o_m_data), .o_m_sel(o_m_sel),
        .i_m_ack(i_m_ack), .i_m_stall(i_m_stall), .i_m_data(i_m_data),
        .o_sweep_done(o_sweep_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Encoder-slave model controls (written by the main sequence).
    logic [31:0] resp [NCH];
    bit          ack_en [NCH];
    int          ack_lat   = 0;
    int          stall_len = 0;
    int          stall_arm = 0;
    int          late_req  = 0;
    // Model-owned state.
    int          stall_seen = 0;
    int          stall_left = 0;
    int          late_seen  = 0;
    bit          pend       = 1'b0;
    logic [31:0] pend_data  = '0;
    logic [29:0] got_addr [64];
    int          got_n      = 0;
    // Main-owned read pointer into got_addr.
    int          got_rd     = 0;

    // Monitor state.
    int done_count = 0;
    int dbl_pulse  = 0;
    int cyc_run    = 0;
    int cyc_last   = 0;
    int cyc_starts = 0;
    bit prev_done  = 1'b0;
    bit prev_cyc   = 1'b0;

    // Scoreboards.
    logic [29:0] exp_addr [$];
    logic [31:0] exp_rd [$];
    string       exp_tag [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Encoder slave: stall/ack behaviour decided each negedge for the next edge.
    initial begin
        i_m_ack   = 1'b0;
        i_m_stall = 1'b0;
        i_m_data  = '0;
        forever begin
            @(negedge i_clk);
            i_m_ack   = 1'b0;
            i_m_data  = '0;
            i_m_stall = 1'b0;
            if (i_reset) begin
                pend = 1'b0;
            end
            if (late_req != late_seen) begin
                late_seen = late_req;
                i_m_ack   = 1'b1;
                i_m_data  = 32'hDEAD_BEEF;
            end else if (pend) begin
                pend     = 1'b0;
                i_m_ack  = 1'b1;
                i_m_data = pend_data;
            end
            if (o_m_cyc && o_m_stb) begin
                if (stall_arm != stall_seen) begin
                    stall_seen = stall_arm;
                    stall_left = stall_len;
                end
                if (stall_left > 0) begin
                    i_m_stall = 1'b1;
                    stall_left--;
                end else begin
                    int chn;
                    chn = int'(o_m_addr - BASE);
                    if (got_n < 64) got_addr[got_n] = o_m_addr;
                    got_n++;
                    if (chn >= 0 && chn < NCH && ack_en[chn]) begin
                        if (ack_lat == 0) begin
                            i_m_ack  = 1'b1;
                            i_m_data = resp[chn];
                        end else begin
                            pend      = 1'b1;
                            pend_data = resp[chn];
                        end
                    end
                end
            end
        end
    end

    // Monitor: sweep-done pulses and master cycle lengths, sampled after each edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #2;
            if (o_sweep_done === 1'b1) begin
                done_count++;
                if (prev_done) dbl_pulse++;
            end
            prev_done = (o_sweep_done === 1'b1);
            if (o_m_cyc === 1'b1) begin
                if (!prev_cyc) cyc_starts++;
                cyc_run++;
            end else if (prev_cyc) begin
                cyc_last = cyc_run;
                cyc_run  = 0;
            end
            prev_cyc = (o_m_cyc === 1'b1);
        end
    end

    task automatic bus_write(input logic [4:0] off, input logic [31:0] data, input string tag);
        @(negedge i_clk);
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b1;
        i_s_addr = {25'd0, off}; i_s_data = data; i_s_sel = 4'hF;
        @(negedge i_clk);
        check({tag, "_ack"}, 32'(o_s_ack), 32'd1);
        i_s_cyc = 1'b0; i_s_stb = 1'b0; i_s_we = 1'b0; i_s_data = '0;
    endtask

    task automatic bus_read(input logic [4:0] off, input logic [31:0] exp, input string tag);
        @(negedge i_clk);
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b0;
        i_s_addr = {25'd0, off}; i_s_sel = 4'hF;
        exp_rd.push_back(exp);
        exp_tag.push_back(tag);
        @(negedge i_clk);
        if (o_s_ack === 1'b1) begin
            check(exp_tag.pop_front(), o_s_data, exp_rd.pop_front());
        end else begin
            check({tag, "_noack"}, 32'(o_s_ack), 32'd1);
            void'(exp_rd.pop_front());
            void'(exp_tag.pop_front());
        end
        i_s_cyc = 1'b0; i_s_stb = 1'b0;
    endtask

    task automatic push_sweep(input int nch);
        for (int k = 0; k < nch; k++) exp_addr.push_back(BASE + 30'(k));
    endtask

    task automatic check_addrs(input string tag);
        while (exp_addr.size() > 0) begin
            if (got_rd < got_n) begin
                check(tag, 32'(got_addr[got_rd]), 32'(exp_addr.pop_front()));
                got_rd++;
            end else begin
                check({tag, "_missing"}, 32'(exp_addr.size()), 32'd0);
                exp_addr.delete();
            end
        end
        check({tag, "_extra"}, 32'(got_n - got_rd), 32'd0);
        got_rd = got_n;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start;
        start = done_count;
        for (int i = 0; i < budget && done_count == start; i++) @(negedge i_clk);
        check(tag, 32'(done_count - start), 32'd1);
    endtask

    task automatic wait_cyc(input int budget, input bit in_wait, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge i_clk);
            hit = (o_m_cyc === 1'b1) && (!in_wait || o_m_stb === 1'b0);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        int starts;
        int dones;
        i_reset = 1'b1;
        i_s_cyc = 1'b0; i_s_stb = 1'b0; i_s_we = 1'b0;
        i_s_addr = '0; i_s_data = '0; i_s_sel = 4'h0;
        for (int k = 0; k < NCH; k++) begin
            resp[k]   = '0;
            ack_en[k] = 1'b1;
        end

        // Reset state.
        repeat (3) @(negedge i_clk);
        check("rst_m_cyc", 32'(o_m_cyc), 32'd0);
        check("rst_m_stb", 32'(o_m_stb), 32'd0);
        check("rst_s_ack", 32'(o_s_ack), 32'd0);
        check("rst_s_data", o_s_data, 32'd0);
        check("rst_done", 32'(o_sweep_done), 32'd0);
        check("const_we_data_sel", {o_m_data[27:0], 3'b000, o_m_we} | 32'(o_m_sel) << 28, 32'hF000_0000);
        check("s_stall", 32'(o_s_stall), 32'd0);
        i_reset = 1'b0;
        bus_read(5'd0, 32'd0, "rst_ctrl");
        bus_read(5'd1, 32'd0, "rst_status");
        bus_read(5'd2, 32'd0, "rst_seq");
        @(negedge i_clk);
        check("s_data_idle", o_s_data, 32'd0);

        // First sweep, same-cycle acks: deltas measured from zero.
        resp[0] = 32'd5; resp[1] = 32'd7; ack_lat = 0;
        push_sweep(2);
        bus_write(5'd0, 32'd1, "en1");
        wait_done(PERIOD + 60, "sweep1_done");
        bus_write(5'd0, 32'd0, "dis1");
        check_addrs("sweep1_addr");
        bus_read(5'd4, 32'd5, "s1_count0");
        bus_read(5'd5, 32'd5, "s1_delta0");
        bus_read(5'd6, 32'd7, "s1_count1");
        bus_read(5'd7, 32'd7, "s1_delta1");
        bus_read(5'd2, 32'd1, "s1_seq");
        bus_read(5'd3, 32'd0, "reserved");
        bus_read(5'd12, 32'd0, "beyond_map");

        // Second sweep through WAIT: modulo deltas.
        resp[0] = 32'd3; resp[1] = 32'hFFFF_FFFF; ack_lat = 1;
        push_sweep(2);
        bus_write(5'd0, 32'd1, "en2");
        wait_done(PERIOD + 60, "sweep2_done");
        bus_write(5'd0, 32'd0, "dis2");
        check_addrs("sweep2_addr");
        bus_read(5'd5, 32'hFFFF_FFFE, "s2_delta0");
        bus_read(5'd7, 32'hFFFF_FFF8, "s2_delta1");
        bus_read(5'd6, 32'hFFFF_FFFF, "s2_count1");
        bus_read(5'd2, 32'd2, "s2_seq");

        // Channel 1 never acks: timeout, err bit, results untouched.
        resp[0] = 32'd10; ack_en[1] = 1'b0;
        push_sweep(2);
        bus_write(5'd0, 32'd1, "en3");
        wait_done(PERIOD + 80, "sweep3_done");
        bus_write(5'd0, 32'd0, "dis3");
        check_addrs("sweep3_addr");
        check("tmo_cyc_len", 32'(cyc_last), 32'(TIMEOUT));
        bus_read(5'd1, 32'h0000_0002, "s3_status_err");
        bus_read(5'd4, 32'd10, "s3_count0");
        bus_read(5'd5, 32'd7, "s3_delta0");
        bus_read(5'd6, 32'hFFFF_FFFF, "s3_count1_kept");
        bus_read(5'd7, 32'hFFFF_FFF8, "s3_delta1_kept");
        bus_read(5'd2, 32'd3, "s3_seq");
        bus_write(5'd1, 32'd1, "clr3");
        bus_read(5'd1, 32'd0, "s3_status_clr");

        // Disable mid-sweep: current sweep completes, nothing afterwards.
        resp[0] = 32'd100; resp[1] = 32'd200; ack_en[1] = 1'b1; ack_lat = 0;
        stall_len = 20; stall_arm++;
        push_sweep(2);
        bus_write(5'd0, 32'd1, "en4");
        wait_cyc(PERIOD + 20, 1'b0, "s4_start");
        bus_read(5'd1, 32'h8000_0000, "s4_busy");
        bus_write(5'd0, 32'd0, "dis4_mid");
        wait_done(60, "sweep4_done");
        starts = cyc_starts; dones = done_count;
        repeat (PERIOD * 2 + 50) @(negedge i_clk);
        check("s4_no_more_cyc", 32'(cyc_starts - starts), 32'd0);
        check("s4_no_more_done", 32'(done_count - dones), 32'd0);
        check_addrs("sweep4_addr");
        bus_read(5'd1, 32'd0, "s4_status");
        bus_read(5'd5, 32'd90, "s4_delta0");
        bus_read(5'd7, 32'd201, "s4_delta1");
        bus_read(5'd2, 32'd4, "s4_seq");

        // Long stall: the tick that lands mid-sweep is dropped as an overrun.
        resp[0] = 32'd1; resp[1] = 32'd2;
        stall_len = 150; stall_arm++;
        push_sweep(2);
        bus_write(5'd0, 32'd1, "en5");
        wait_done(PERIOD + 250, "sweep5_done");
        bus_write(5'd0, 32'd0, "dis5");
        check_addrs("sweep5_addr");
        bus_read(5'd1, 32'h0001_0000, "s5_overrun");
        bus_read(5'd2, 32'd5, "s5_seq");
        bus_read(5'd4, 32'd1, "s5_count0");
        bus_write(5'd1, 32'd1, "clr5");
        bus_read(5'd1, 32'd0, "s5_status_clr");

        // Reset while waiting for an ack; a late ack afterwards is ignored.
        ack_en[0] = 1'b0; ack_en[1] = 1'b0; ack_lat = 1;
        push_sweep(1);
        bus_write(5'd0, 32'd1, "en6");
        wait_cyc(PERIOD + 20, 1'b1, "s6_in_wait");
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rst_drop_cyc", 32'(o_m_cyc), 32'd0);
        i_reset = 1'b0;
        late_req++;
        starts = cyc_starts;
        repeat (4) @(negedge i_clk);
        check_addrs("sweep6_addr");
        bus_read(5'd0, 32'd0, "r_ctrl");
        bus_read(5'd1, 32'd0, "r_status");
        bus_read(5'd2, 32'd0, "r_seq");
        bus_read(5'd4, 32'd0, "r_count0");
        bus_read(5'd5, 32'd0, "r_delta0");
        bus_read(5'd6, 32'd0, "r_count1");
        bus_read(5'd7, 32'd0, "r_delta1");
        repeat (PERIOD * 2 + 50) @(negedge i_clk);
        check("r_no_sweep", 32'(cyc_starts - starts), 32'd0);

        // Re-enable after reset: first sweep reports count - 0 again.
        resp[0] = 32'd9; resp[1] = 32'd4; ack_en[0] = 1'b1; ack_en[1] = 1'b1;
        push_sweep(2);
        bus_write(5'd0, 32'd1, "en7");
        wait_done(PERIOD + 60, "sweep7_done");
        bus_write(5'd0, 32'd0, "dis7");
        check_addrs("sweep7_addr");
        bus_read(5'd5, 32'd9, "s7_delta0");
        bus_read(5'd7, 32'd4, "s7_delta1");
        bus_read(5'd2, 32'd1, "s7_seq");
        check("done_single_cycle", 32'(dbl_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
